seq_chunk_adder: RTL

SEQ_CHUNK_ADDER -- requirements
Module: seq_chunk_adder

---
 rtl/seq_chunk_adder.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/seq_chunk_adder.sv
// ---------------------------------------------------------------------------
// seq_chunk_adder
//
// Multi-cycle adder/subtractor. It adds two WIDTH-bit operands CHUNK bits per
// clock, so one operation takes N = WIDTH/CHUNK RUN cycles. Subtraction is
// done as a + ~b + 1. The operands and the carry-in mode are captured when
// start is accepted. After that the inputs are ignored until the result is
// published.
//
// Ports
//   clk    in   single clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   request a new operation (accepted in IDLE or DONE)
//   sub    in   0 = a + b + cin, 1 = a - b
//   a, b   in   WIDTH-bit operands
//   cin    in   carry-in, add mode only
//   busy   out  high for exactly the N RUN cycles of an operation
//   done   out  one-cycle pulse while the result is first presented
//   s      out  registered sum/difference (modulo 2^WIDTH)
//   c      out  registered carry-out of the MSB (NOT borrow when subtracting)
//   v      out  registered two's-complement overflow
// ---------------------------------------------------------------------------
module seq_chunk_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             c,
    output logic             v
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int BW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             carry;

    // Captured operands (b already inverted for subtract) and partial result.
    // These never feed control decisions, so they carry no reset.
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;

    logic [BW-1:0]    base;
    logic [CHUNK:0]   chunk_sum;
    logic [WIDTH-1:0] next_res;
    logic             last;
    logic             accept;

    // start is honoured only when no operation is in flight.
    assign accept = start && (state != RUN);
    assign last   = (idx == IDX_W'(N - 1));

    // Chunk datapath: bit offset of the current chunk, its sum with the
    // stored carry, and the result register with that chunk merged in. At
    // the last chunk, next_res is the complete result. That lets s load it
    // on the same edge as the final chunk.
    always_comb begin
        base      = BW'(idx) * BW'(CHUNK);
        chunk_sum = {1'b0, a_q[base +: CHUNK]} + {1'b0, b_q[base +: CHUNK]}
                    + {{CHUNK{1'b0}}, carry};
        next_res  = res_q;
        next_res[base +: CHUNK] = chunk_sum[CHUNK-1:0];
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= a;
            b_q <= sub ? ~b : b;
        end
        if (state == RUN) begin
            res_q <= next_res;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            idx   <= '0;
            carry <= 1'b0;
            s     <= '0;
            c     <= 1'b0;
            v     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        idx   <= '0;
                        // Subtract supplies the +1 of the two's complement.
                        carry <= sub ? 1'b1 : cin;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    carry <= chunk_sum[CHUNK];
                    idx   <= idx + 1'b1;
                    if (last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        s     <= next_res;
                        c     <= chunk_sum[CHUNK];
                        // Overflow: operands agree in sign but the result does not.
                        v     <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                 (next_res[WIDTH-1] != a_q[WIDTH-1]);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
